// File: rtl/serial_adder_sub_pkg.sv
// serial_adder_sub_pkg: shared state encoding and operation-mode constants
package serial_adder_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_sub_fa_cell.sv
// serial_adder_sub_fa_cell: one-bit full adder built from two half adders and an OR

module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // sum and carry of two bits
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder_cell u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder_cell u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    // a carry from either half adder propagates out
    always_comb cout = c0 | c1;

endmodule

// File: rtl/serial_adder_sub.sv
// serial_adder_sub: bit-serial W-bit adder/subtractor, one bit per clock, LSB first
module serial_adder_sub
    import serial_adder_sub_pkg::*;
#(
    parameter  int W     = 4,
    localparam int CNT_W = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       shift_a_q, shift_a_d;
    logic [W-1:0]       shift_b_q, shift_b_d;
    logic [W-2:0]       shift_s_q, shift_s_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fa_s;
    logic               fa_co;
    logic [W-1:0]       s_next;

    fa_cell u_fa (
        .a    (shift_a_q[0]),
        .b    (shift_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    // partial result with the newest sum bit entering at the MSB
    always_comb s_next = {fa_s, shift_s_q};

    // next-state logic: load on start, shift one bit per RUN cycle, publish on the last bit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        shift_s_d = shift_s_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    shift_a_d = a;
                    shift_b_d = (sub == OP_ADD) ? b : ~b;
                    carry_d   = (sub == OP_SUB);
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_d    = 1'b1;
                shift_s_d = s_next[W-1:1];
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                carry_d   = fa_co;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W - 1)) begin
                    sum_d   = s_next;
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_a_q <= '0;
            shift_b_q <= '0;
            shift_s_q <= '0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            shift_s_q <= shift_s_d;
            carry_q   <= carry_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // registered outputs
    always_comb begin
        busy = busy_q;
        done = done_q;
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

endmodule
